// File: rtl/fetch_pkg.sv
// Shared fetch definitions: word geometry and the fetch FSM state set.
// Imported by fetch_sequencer and byte_word_assembler.
package fetch_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int IDX_W          = 2;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      HOLD
   } fetch_state_e;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs returning instruction bytes into a 32-bit word, MSB first.
// Ports: clk, rst (sync, active-low), clear, pend, idx, rdata -> word.
module byte_word_assembler
   import fetch_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             pend,
   input  logic [IDX_W-1:0] idx,
   input  logic [7:0]       rdata,
   output logic [31:0]      word
);

   logic [4:0] lsb;

   // Byte k lands in bits [31-8k -: 8], i.e. base 8*(3-k).
   assign lsb = {~idx, 3'b000};

   always_ff @(posedge clk) begin
      if (!rst) begin
         word <= '0;
      end else if (clear) begin
         word <= '0;
      end else if (pend) begin
         word[lsb +: 8] <= rdata;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, reads four bytes per word, hands words to decode.
// Ports: clk, rst, enable, redirect/redirect_pc, mem_* byte port, instr* handshake, busy.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int          ADDR_W   = 7,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK =
      ~ADDR_W'(BYTES_PER_WORD - 1);
   localparam logic [ADDR_W-1:0] PC0 =
      ADDR_W'(RESET_PC) & ALIGN_MASK;
   localparam logic [IDX_W-1:0] LAST =
      IDX_W'(BYTES_PER_WORD - 1);

   fetch_state_e      state, state_n;
   logic [ADDR_W-1:0] pc, pc_n;
   logic [ADDR_W-1:0] ipc_n;
   logic [IDX_W-1:0]  cnt, cnt_n;
   logic              pend, pend_n;
   logic [IDX_W-1:0]  pidx;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         pc       <= PC0;
         cnt      <= '0;
         pend     <= 1'b0;
         pidx     <= '0;
         instr_pc <= '0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         cnt      <= cnt_n;
         pend     <= pend_n;
         pidx     <= cnt;
         instr_pc <= ipc_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      cnt_n   = cnt;
      ipc_n   = instr_pc;
      // The byte read in a redirect cycle is never captured.
      pend_n  = mem_rd_en & ~redirect;
      if (redirect) begin
         state_n = enable ? FETCH : IDLE;
         pc_n    = redirect_pc & ALIGN_MASK;
         cnt_n   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt_n = '0;
               if (enable) state_n = FETCH;
            end
            FETCH: begin
               cnt_n = cnt + IDX_W'(1);
               if (cnt == LAST) state_n = DRAIN;
            end
            DRAIN: begin
               state_n = HOLD;
               ipc_n   = pc;
            end
            HOLD: begin
               if (instr_ready) begin
                  pc_n    = pc + ADDR_W'(BYTES_PER_WORD);
                  state_n = enable ? FETCH : IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // pc is word aligned, so pc+cnt is a plain concatenation.
   assign mem_rd_en   = (state == FETCH);
   assign mem_addr    = mem_rd_en ? {pc[ADDR_W-1:IDX_W], cnt} : '0;
   assign instr_valid = (state == HOLD);
   assign busy        = (state != IDLE);

   byte_word_assembler u_asm (
      .clk   (clk),
      .rst   (rst),
      .clear (redirect),
      .pend  (pend),
      .idx   (pidx),
      .rdata (mem_rdata),
      .word  (instr)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a byte memory model.
// Two instances: default RESET_PC and RESET_PC=124 for wrap-around.
module tb_fetch_sequencer;

   localparam int AW = 7;

   logic          clk = 1'b0;
   logic          rst, enable, redirect, instr_ready;
   logic [AW-1:0] redirect_pc;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata;
   logic [31:0]   instr;
   logic [AW-1:0] instr_pc;
   logic          instr_valid, busy;

   logic          h_rst, h_enable, h_redirect, h_ready;
   logic [AW-1:0] h_redirect_pc;
   logic          h_rd_en;
   logic [AW-1:0] h_addr;
   logic [7:0]    h_rdata;
   logic [31:0]   h_instr;
   logic [AW-1:0] h_ipc;
   logic          h_valid, h_busy;

   logic [7:0] mem [128];
   int chk = 0;
   int pass = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(.ADDR_W(AW), .RESET_PC(0)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .instr(instr),
      .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .busy(busy)
   );

   fetch_sequencer #(.ADDR_W(AW), .RESET_PC(124)) dut_hi (
      .clk(clk), .rst(h_rst), .enable(h_enable),
      .redirect(h_redirect), .redirect_pc(h_redirect_pc),
      .mem_rd_en(h_rd_en), .mem_addr(h_addr),
      .mem_rdata(h_rdata), .instr(h_instr),
      .instr_pc(h_ipc), .instr_valid(h_valid),
      .instr_ready(h_ready), .busy(h_busy)
   );

   // Byte store: data one cycle after a strobe, garbage otherwise.
   always @(posedge clk) begin
      mem_rdata <= mem_rd_en ? mem[mem_addr] : 8'($urandom);
      h_rdata   <= h_rd_en ? mem[h_addr] : 8'($urandom);
   end

   function automatic logic [31:0] word_at(input logic [AW-1:0] a);
      logic [AW-1:0] b;
      b = a & 7'h7C;
      return {mem[b], mem[b + 7'd1], mem[b + 7'd2], mem[b + 7'd3]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; enable = 1'b1; instr_ready = 1'b1;
      redirect = 1'b0; redirect_pc = '0;
      tick(); tick(); tick();
      chk++;
      if ({mem_rd_en, mem_addr, instr, instr_pc, instr_valid, busy} !== '0)
         $display("FAIL reset_outputs: got rd=%b a=%h i=%h pc=%h v=%b b=%b want all 0",
                  mem_rd_en, mem_addr, instr, instr_pc, instr_valid, busy);
      else pass++;
   endtask

   task automatic test_basic();
      rst = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk++;
         if (mem_rd_en !== 1'b1 || mem_addr !== AW'(k))
            $display("FAIL basic_read%0d: got rd=%b a=%h want rd=1 a=%h",
                     k, mem_rd_en, mem_addr, AW'(k));
         else pass++;
         tick();
      end
      chk++;
      if (mem_rd_en !== 1'b0 || instr_valid !== 1'b0)
         $display("FAIL basic_drain: got rd=%b v=%b want 0 0", mem_rd_en, instr_valid);
      else pass++;
      tick();
      chk++;
      if (instr_valid !== 1'b1 || instr !== 32'hE3A01005 || instr_pc !== 7'd0)
         $display("FAIL basic_word: got v=%b i=%h pc=%h want 1 e3a01005 00",
                  instr_valid, instr, instr_pc);
      else pass++;
      tick();
      chk++;
      if (mem_rd_en !== 1'b1 || mem_addr !== 7'd4)
         $display("FAIL basic_next: got rd=%b a=%h want 1 04", mem_rd_en, mem_addr);
      else pass++;
   endtask

   task automatic test_hold();
      logic seen;
      instr_ready = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         tick();
         seen = instr_valid;
      end
      chk++;
      if (!seen) $display("FAIL hold_timeout: got no valid want valid within 10");
      else pass++;
      for (int h = 0; h < 4; h++) begin
         chk++;
         if (instr_valid !== 1'b1 || instr !== word_at(7'd4) ||
             instr_pc !== 7'd4 || mem_rd_en !== 1'b0)
            $display("FAIL hold_stable%0d: got v=%b i=%h pc=%h rd=%b want 1 %h 04 0",
                     h, instr_valid, instr, instr_pc, mem_rd_en, word_at(7'd4));
         else pass++;
         tick();
      end
      chk++;
      if (instr_valid !== 1'b1 || instr_pc !== 7'd4)
         $display("FAIL hold_5th: got v=%b pc=%h want 1 04", instr_valid, instr_pc);
      else pass++;
      instr_ready = 1'b1;
      tick();
      chk++;
      if (mem_rd_en !== 1'b1 || mem_addr !== 7'd8)
         $display("FAIL hold_next: got rd=%b a=%h want 1 08", mem_rd_en, mem_addr);
      else pass++;
   endtask

   task automatic test_redirect();
      tick();
      tick();
      redirect = 1'b1; redirect_pc = 7'h2B;
      tick();
      redirect = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk++;
         if (mem_rd_en !== 1'b1 || mem_addr !== 7'h28 + AW'(k))
            $display("FAIL redir_read%0d: got rd=%b a=%h want 1 %h",
                     k, mem_rd_en, mem_addr, 7'h28 + AW'(k));
         else pass++;
         if (k < 3) tick();
      end
      tick();
      chk++;
      if (instr_valid !== 1'b0)
         $display("FAIL redir_early: got v=%b want 0", instr_valid);
      else pass++;
      tick();
      chk++;
      if (instr_valid !== 1'b1 || instr !== word_at(7'h28) || instr_pc !== 7'h28)
         $display("FAIL redir_word: got v=%b i=%h pc=%h want 1 %h 28",
                  instr_valid, instr, instr_pc, word_at(7'h28));
      else pass++;
   endtask

   task automatic test_enable_drop();
      tick();
      chk++;
      if (mem_rd_en !== 1'b1 || mem_addr !== 7'h2C)
         $display("FAIL en_t0: got rd=%b a=%h want 1 2c", mem_rd_en, mem_addr);
      else pass++;
      tick();
      enable = 1'b0;
      tick(); tick(); tick(); tick();
      chk++;
      if (instr_valid !== 1'b1 || instr !== word_at(7'h2C) || instr_pc !== 7'h2C)
         $display("FAIL en_word: got v=%b i=%h pc=%h want 1 %h 2c",
                  instr_valid, instr, instr_pc, word_at(7'h2C));
      else pass++;
      tick();
      for (int n = 0; n < 3; n++) begin
         chk++;
         if (busy !== 1'b0 || mem_rd_en !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL en_idle%0d: got b=%b rd=%b v=%b want 0 0 0",
                     n, busy, mem_rd_en, instr_valid);
         else pass++;
         tick();
      end
      enable = 1'b1;
      tick();
      chk++;
      if (mem_rd_en !== 1'b1 || mem_addr !== 7'h30 || busy !== 1'b1)
         $display("FAIL en_resume: got rd=%b a=%h b=%b want 1 30 1",
                  mem_rd_en, mem_addr, busy);
      else pass++;
   endtask

   task automatic test_reset_mid();
      tick(); tick(); tick();
      rst = 1'b0;
      tick();
      chk++;
      if ({mem_rd_en, mem_addr, instr, instr_pc, instr_valid, busy} !== '0)
         $display("FAIL rstmid_outputs: got rd=%b a=%h i=%h pc=%h v=%b b=%b want all 0",
                  mem_rd_en, mem_addr, instr, instr_pc, instr_valid, busy);
      else pass++;
      rst = 1'b1; enable = 1'b0;
      tick();
      chk++;
      if (mem_rd_en !== 1'b0 || busy !== 1'b0)
         $display("FAIL rstmid_idle: got rd=%b b=%b want 0 0", mem_rd_en, busy);
      else pass++;
      enable = 1'b1;
      tick();
      chk++;
      if (mem_rd_en !== 1'b1 || mem_addr !== 7'd0)
         $display("FAIL rstmid_first: got rd=%b a=%h want 1 00", mem_rd_en, mem_addr);
      else pass++;
   endtask

   task automatic test_wrap();
      chk++;
      if ({h_rd_en, h_addr, h_instr, h_ipc, h_valid, h_busy} !== '0)
         $display("FAIL wrap_reset: got rd=%b a=%h i=%h pc=%h v=%b b=%b want all 0",
                  h_rd_en, h_addr, h_instr, h_ipc, h_valid, h_busy);
      else pass++;
      h_rst = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk++;
         if (h_rd_en !== 1'b1 || h_addr !== 7'd124 + AW'(k))
            $display("FAIL wrap_read%0d: got rd=%b a=%h want 1 %h",
                     k, h_rd_en, h_addr, 7'd124 + AW'(k));
         else pass++;
         tick();
      end
      tick();
      chk++;
      if (h_valid !== 1'b1 || h_instr !== word_at(7'd124) || h_ipc !== 7'd124)
         $display("FAIL wrap_word: got v=%b i=%h pc=%h want 1 %h 7c",
                  h_valid, h_instr, h_ipc, word_at(7'd124));
      else pass++;
      tick();
      chk++;
      if (h_rd_en !== 1'b1 || h_addr !== 7'd0)
         $display("FAIL wrap_next: got rd=%b a=%h want 1 00", h_rd_en, h_addr);
      else pass++;
   endtask

   // Model: the word being fetched/held always belongs to exp_pc,
   // which advances by 4 per handshake and jumps on redirect.
   task automatic test_random();
      logic [AW-1:0] exp_pc;
      logic          sync, pv, phs, prd;
      logic [31:0]   pi;
      logic [AW-1:0] pp;
      int            words, errs;
      sync = 1'b0; pv = 1'b0; phs = 1'b0; prd = 1'b0;
      pi = '0; pp = '0; exp_pc = '0;
      words = 0; errs = 0;
      for (int c = 0; c < 800; c++) begin
         tick();
         if (sync && pv && !phs && !prd) begin
            chk++;
            if (instr_valid !== 1'b1 || instr !== pi || instr_pc !== pp) begin
               $display("FAIL rnd_stable c%0d: got v=%b i=%h pc=%h want 1 %h %h",
                        c, instr_valid, instr, instr_pc, pi, pp);
            end else pass++;
         end
         if (sync && mem_rd_en) begin
            chk++;
            if (mem_addr[AW-1:2] !== exp_pc[AW-1:2])
               $display("FAIL rnd_addr c%0d: got a=%h want word %h",
                        c, mem_addr, exp_pc);
            else pass++;
         end
         if (c == 0) begin
            instr_ready = 1'b0;
            redirect = 1'b1;
         end else begin
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 15) == 0);
         end
         redirect_pc = AW'($urandom);
         enable = ($urandom_range(0, 7) != 0);
         phs = instr_valid && instr_ready;
         if (sync && phs) begin
            chk++;
            if (instr !== word_at(exp_pc) || instr_pc !== exp_pc)
               $display("FAIL rnd_word c%0d: got i=%h pc=%h want %h %h",
                        c, instr, instr_pc, word_at(exp_pc), exp_pc);
            else pass++;
            words++;
            exp_pc = exp_pc + 7'd4;
         end
         if (redirect) begin
            exp_pc = redirect_pc & 7'h7C;
            sync = 1'b1;
         end
         prd = redirect;
         pv = instr_valid; pi = instr; pp = instr_pc;
      end
      redirect = 1'b0;
      chk++;
      if (words < 10)
         $display("FAIL rnd_progress: got %0d words want >= 10", words);
      else pass++;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
      mem[0] = 8'hE3; mem[1] = 8'hA0; mem[2] = 8'h10; mem[3] = 8'h05;
      mem[10] = ~mem[7'h2A];
      h_rst = 1'b0; h_enable = 1'b1; h_ready = 1'b1;
      h_redirect = 1'b0; h_redirect_pc = '0;
      test_reset();
      test_basic();
      test_hold();
      test_redirect();
      test_enable_drop();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences the byte-wide instruction memory to deliver one aligned 32-bit instruction at a time to the decode stage. Owns the PC, issues four consecutive byte reads, assembles them most-significant-byte first, and presents the word through a valid/ready handshake. Sits between the branch/redirect logic and the instruction byte store.

## Interface
- `ADDR_W`, default 7: byte-address width; the memory holds 2^ADDR_W bytes, default 128.
- `RESET_PC`, default 0: PC after reset; bits [1:0] are forced to 0.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `enable` in 1: permits starting a new word fetch.
- `redirect` in 1: one-cycle pulse that loads a new PC and flushes the fetch in flight.
- `redirect_pc` in ADDR_W: target address; bits [1:0] are ignored and treated as 0.
- `mem_rd_en` out 1: byte read strobe.
- `mem_addr` out ADDR_W: byte read address.
- `mem_rdata` in 8: read data, valid exactly one cycle after a strobed address.
- `instr` out 32: assembled word, {byte@pc, byte@pc+1, byte@pc+2, byte@pc+3}.
- `instr_pc` out ADDR_W: address of `instr`.
- `instr_valid` out 1: `instr` and `instr_pc` are valid.
- `instr_ready` in 1: decode accepts the word.
- `busy` out 1: state is not IDLE.

## Operation
- States:
  - IDLE: no reads.
  - FETCH: issue counter `cnt` runs 0..3; `mem_rd_en`=1 and `mem_addr`=pc+cnt.
  - DRAIN: no read; the last byte is captured.
  - HOLD: `instr_valid`=1.
- Transitions:
  - IDLE→FETCH when `enable`=1.
  - FETCH with cnt=3 → DRAIN.
  - DRAIN → HOLD.
  - HOLD with `instr_ready`=1 → FETCH at pc+4 if `enable`=1, otherwise IDLE at pc+4.
- `enable` is sampled only in IDLE and on a HOLD handshake. Deasserting it mid-word does not abort the word.
- Byte capture uses a registered pending flag plus index that trail the issue by one cycle. Byte k is written into `instr` bits [31-8k -: 8].
- `instr` and `instr_pc` stay stable while HOLD waits for `instr_ready`.
- PC arithmetic is modulo 2^ADDR_W. Words are aligned, so pc+3 never wraps mid-word; pc = 2^ADDR_W-4 increments to 0.
- Redirect has highest priority in every non-reset state, including a HOLD handshake cycle. In that case the word counts as transferred and the new PC still comes from `redirect_pc`.
- Effects of a redirect on the next cycle:
  - pc ← {redirect_pc[ADDR_W-1:2], 2'b00}.
  - cnt ← 0.
  - The pending flag is cleared, so the byte returning from the redirect-cycle read is discarded.
  - `instr_valid` ← 0.
  - State becomes FETCH if `enable`=1, otherwise IDLE.
- Reset, including mid-fetch: state IDLE, pc=RESET_PC, cnt=0, pending flag cleared. All outputs are 0: `mem_rd_en`, `mem_addr`, `instr`, `instr_pc`, `instr_valid`, `busy`.

## Timing
- `mem_rd_en` and `mem_addr` are decoded from registered state, with no path from any input to them.
- Latency, with t0 = first FETCH cycle:
  - Reads issue at t0..t3.
  - Bytes are captured at the end of t1..t4 (t4 is DRAIN).
  - `instr_valid` rises at t5.
- When `instr_ready` is held high, a handshake at t5 starts the next FETCH at t6. Throughput is one word per 6 cycles.
- From an `enable` rise while in IDLE, the first read issues on the next cycle.
- A redirect in cycle r gives the first read at the new PC in cycle r+1 and `instr_valid` at r+6.
- `instr_valid` never drops without a handshake, a redirect, or a reset.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum (IDLE, FETCH, DRAIN, HOLD);
  - `BYTES_PER_WORD`=4;
  - `IDX_W`=2.
- Sub-module `byte_word_assembler` takes the pending flag, index and `mem_rdata`, and produces the 32-bit word with a clear input.
- The top level holds the FSM, PC and counters.

## Test plan
- Preload bytes 0..3 = E3 A0 10 05, hold `enable`=1 and `instr_ready`=1, reset then release → `mem_addr` 0,1,2,3 on t0..t3; `instr`=32'hE3A01005, `instr_pc`=0, `instr_valid`=1 at t5; next read of address 4 at t6.
- Set `instr_ready`=0 for 4 cycles during HOLD → `instr_valid`, `instr` and `instr_pc` stay stable and `mem_rd_en`=0 throughout; handshake on the 5th cycle → FETCH at pc+4.
- Pulse `redirect` with `redirect_pc`=7'h2B in cycle t2 of a fetch → next cycle `mem_addr`=7'h28; the stale byte is discarded; the delivered word has `instr_pc`=7'h28 and matches bytes 28..2B.
- Start with pc=124 (`RESET_PC`=124) and ready held high → reads at 124..127, word delivered, next `mem_addr`=0.
- Deassert `enable` at t1 → word still delivered at t5; after the handshake the block goes IDLE with `busy`=0 and no further reads; re-enable → FETCH at pc+4.
- Assert `rst`=0 at t3 → next cycle every output is 0 and state is IDLE; release → first read at `RESET_PC` on the cycle after `enable` is sampled.
